// File: rtl/br_pkg.sv
// Shared definitions for the execute-stage branch resolver: funct3 codes,
// predictor state encodings, the prediction queue entry and the outcome compare.
package br_pkg;

    localparam int unsigned BR_XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] ST_T = 2'b11;
    localparam logic [1:0] ST_t = 2'b10;
    localparam logic [1:0] ST_n = 2'b01;
    localparam logic [1:0] ST_N = 2'b00;

    typedef struct packed {
        logic [BR_XLEN-1:0] pc;
        logic               pred_taken;
    } br_entry_t;

    // Reserved funct3 codes resolve as not-taken.
    function automatic logic br_taken(input logic [2:0] f3,
                                      input logic [BR_XLEN-1:0] a,
                                      input logic [BR_XLEN-1:0] b);
        logic r;
        case (f3)
            F3_BEQ:  r = (a == b);
            F3_BNE:  r = (a != b);
            F3_BLT:  r = ($signed(a) < $signed(b));
            F3_BGE:  r = ($signed(a) >= $signed(b));
            F3_BLTU: r = (a < b);
            F3_BGEU: r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic br_f3_legal(input logic [2:0] f3);
        return !(f3 == 3'b010 || f3 == 3'b011);
    endfunction

endpackage

// File: rtl/br_fifo.sv
// Synchronous FIFO with clear; a pop frees a slot for a same-cycle push when full.
module br_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves queued fetch predictions against EX operands, feeds the predictor its
// actual outcome and redirects fetch on a mispredict. XLEN must equal BR_XLEN.
module branch_resolver
    import br_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = BR_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_valid,
    input  logic [1:0]      pred_state,
    input  logic [XLEN-1:0] pred_pc,
    input  logic            res_valid,
    input  logic [2:0]      res_funct3,
    input  logic [XLEN-1:0] res_rs1,
    input  logic [XLEN-1:0] res_rs2,
    input  logic [XLEN-1:0] res_imm,
    output logic            upd_valid,
    output logic            history,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            err,
    output logic [31:0]     br_count,
    output logic [31:0]     miss_count
);
    br_entry_t       wr_entry, head;
    logic            fifo_full, fifo_empty;
    logic            resolve, taken, illegal, miss, flush;
    logic [XLEN-1:0] target, fallthrough;
    logic            unused_pred_lsb;

    logic            upd_valid_q, upd_valid_d;
    logic            history_q, history_d;
    logic            mispredict_q, mispredict_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            overflow_q, overflow_d;
    logic            err_q, err_d;
    logic [31:0]     br_count_q, br_count_d;
    logic [31:0]     miss_count_q, miss_count_d;

    // Only the direction bit of the counter state is kept in the queue.
    assign unused_pred_lsb = pred_state[0];
    assign wr_entry        = '{pc: pred_pc, pred_taken: pred_state[1]};

    br_fifo #(
        .Depth (DEPTH),
        .Width ($bits(br_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pred_valid),
        .pop_i   (res_valid),
        .clear_i (flush),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign resolve     = res_valid && !fifo_empty;
    assign taken       = br_taken(res_funct3, res_rs1, res_rs2);
    assign illegal     = !br_f3_legal(res_funct3);
    assign target      = head.pc + res_imm;
    assign fallthrough = head.pc + XLEN'(4);
    assign miss        = taken ^ head.pred_taken;
    // Younger entries, including a same-cycle push, are wrong-path on a mispredict.
    assign flush       = resolve && miss;

    always_comb begin
        upd_valid_d   = resolve;
        mispredict_d  = flush;
        history_d     = resolve ? taken : history_q;
        redirect_pc_d = resolve ? (taken ? target : fallthrough) : redirect_pc_q;
        overflow_d    = overflow_q || (pred_valid && fifo_full && !resolve);
        err_d         = err_q || (res_valid && fifo_empty) || (resolve && illegal);
        br_count_d    = br_count_q;
        miss_count_d  = miss_count_q;
        if (resolve && br_count_q != '1) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (flush && miss_count_q != '1) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_q   <= 1'b0;
            history_q     <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            overflow_q    <= 1'b0;
            err_q         <= 1'b0;
            br_count_q    <= '0;
            miss_count_q  <= '0;
        end else begin
            upd_valid_q   <= upd_valid_d;
            history_q     <= history_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            overflow_q    <= overflow_d;
            err_q         <= err_d;
            br_count_q    <= br_count_d;
            miss_count_q  <= miss_count_d;
        end
    end

    assign upd_valid   = upd_valid_q;
    assign history     = history_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;
    assign overflow    = overflow_q;
    assign err         = err_q;
    assign br_count    = br_count_q;
    assign miss_count  = miss_count_q;
    assign full        = fifo_full;
    assign empty       = fifo_empty;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: expected update pulses go into a scoreboard
// queue that a negedge monitor drains; status and counters are checked inline.
module tb_branch_resolver;
    import br_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [1:0]  pred_state;
    logic [31:0] pred_pc;
    logic        res_valid;
    logic [2:0]  res_funct3;
    logic [31:0] res_rs1, res_rs2, res_imm;
    logic        upd_valid, history, mispredict, full, empty, overflow, err;
    logic [31:0] redirect_pc, br_count, miss_count;

    typedef struct {
        logic        hist;
        logic        mis;
        logic [31:0] redir;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    branch_resolver #(.DEPTH(4), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pred_valid  (pred_valid),
        .pred_state  (pred_state),
        .pred_pc     (pred_pc),
        .res_valid   (res_valid),
        .res_funct3  (res_funct3),
        .res_rs1     (res_rs1),
        .res_rs2     (res_rs2),
        .res_imm     (res_imm),
        .upd_valid   (upd_valid),
        .history     (history),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .err         (err),
        .br_count    (br_count),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] pc, input logic [1:0] st);
        pred_valid = 1'b1;
        pred_pc    = pc;
        pred_state = st;
        tick();
        pred_valid = 1'b0;
    endtask

    task automatic do_resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic eh, input logic em,
                              input logic [31:0] er);
        exp_t e;
        e.hist = eh;
        e.mis  = em;
        e.redir = er;
        sb.push_back(e);
        res_valid  = 1'b1;
        res_funct3 = f3;
        res_rs1    = a;
        res_rs2    = b;
        res_imm    = imm;
        tick();
        res_valid = 1'b0;
    endtask

    // Monitor: every update pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (upd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_upd", 32'(upd_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_history", 32'(history), 32'(e.hist));
                check("upd_mispredict", 32'(mispredict), 32'(e.mis));
                check("upd_redirect_pc", redirect_pc, e.redir);
            end
        end else if (mispredict) begin
            check("mispredict_without_upd", 32'(mispredict), 32'd0);
        end
    end

    initial begin
        rst = 1'b1;
        pred_valid = 1'b0; pred_state = ST_N; pred_pc = '0;
        res_valid = 1'b0; res_funct3 = F3_BEQ; res_rs1 = '0; res_rs2 = '0; res_imm = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_history", 32'(history), 32'd0);
        check("rst_mispredict", 32'(mispredict), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_br_count", br_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);

        // Weakly not-taken BEQ that is actually taken.
        do_push(32'h100, ST_n);
        do_resolve(F3_BEQ, 32'd5, 32'd5, 32'h20, 1'b1, 1'b1, 32'h120);
        check("beq_empty", 32'(empty), 32'd1);
        check("beq_miss_count", miss_count, 32'd1);
        check("beq_br_count", br_count, 32'd1);

        // Signed vs unsigned compare of the same operands.
        do_push(32'h200, ST_T);
        do_resolve(F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h1F8);
        check("blt_br_count", br_count, 32'd2);
        check("blt_miss_count", miss_count, 32'd1);
        do_push(32'h200, ST_T);
        do_resolve(F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h204);
        check("bltu_br_count", br_count, 32'd3);
        check("bltu_miss_count", miss_count, 32'd2);

        // Fill, overflow, then push+pop while full.
        do_push(32'h300, ST_N);
        do_push(32'h304, ST_N);
        do_push(32'h308, ST_N);
        do_push(32'h30C, ST_N);
        check("fill_full", 32'(full), 32'd1);
        check("fill_no_overflow", 32'(overflow), 32'd0);
        do_push(32'h310, ST_N);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_full", 32'(full), 32'd1);
        pred_valid = 1'b1; pred_pc = 32'h314; pred_state = ST_N;
        do_resolve(F3_BNE, 32'd1, 32'd1, 32'h40, 1'b0, 1'b0, 32'h304);
        pred_valid = 1'b0;
        check("pushpop_full", 32'(full), 32'd1);
        check("pushpop_overflow_clean", 32'(overflow), 32'd1);
        do_resolve(F3_BGE, 32'd0, 32'd1, 32'h40, 1'b0, 1'b0, 32'h308);
        do_resolve(F3_BGE, 32'd0, 32'd1, 32'h40, 1'b0, 1'b0, 32'h30C);
        do_resolve(F3_BGE, 32'd0, 32'd1, 32'h40, 1'b0, 1'b0, 32'h310);
        do_resolve(F3_BGE, 32'd0, 32'd1, 32'h40, 1'b0, 1'b0, 32'h318);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_br_count", br_count, 32'd8);
        check("drain_miss_count", miss_count, 32'd2);

        // Mispredict flushes the younger entry and the same-cycle push.
        do_push(32'h400, ST_t);
        do_push(32'h404, ST_N);
        pred_valid = 1'b1; pred_pc = 32'h500; pred_state = ST_T;
        do_resolve(F3_BGEU, 32'd1, 32'd2, 32'h80, 1'b0, 1'b1, 32'h404);
        pred_valid = 1'b0;
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_full", 32'(full), 32'd0);
        tick();
        tick();
        check("flush_br_count", br_count, 32'd9);
        check("flush_miss_count", miss_count, 32'd3);
        check("pre_err", 32'(err), 32'd0);

        // Resolve with nothing queued.
        res_valid = 1'b1; res_funct3 = F3_BEQ;
        tick();
        res_valid = 1'b0;
        check("empty_res_upd", 32'(upd_valid), 32'd0);
        check("empty_res_err", 32'(err), 32'd1);
        check("empty_res_br_count", br_count, 32'd9);

        // Reset with an in-flight resolve: no pulse, state cleared.
        do_push(32'h700, ST_T);
        rst = 1'b1; res_valid = 1'b1; res_funct3 = F3_BEQ;
        tick();
        rst = 1'b0; res_valid = 1'b0;
        check("midrst_upd", 32'(upd_valid), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_br_count", br_count, 32'd0);

        // Reserved funct3 still pops and reports not-taken.
        do_push(32'h600, ST_N);
        do_resolve(3'b010, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 32'h604);
        check("f3_err", 32'(err), 32'd1);
        check("f3_empty", 32'(empty), 32'd1);
        check("f3_br_count", br_count, 32'd1);
        check("f3_miss_count", miss_count, 32'd0);

        // Fallthrough wraps past the top of the address space.
        do_push(32'hFFFF_FFFC, ST_t);
        do_resolve(F3_BEQ, 32'd1, 32'd2, 32'h40, 1'b0, 1'b1, 32'h0);
        check("wrap_br_count", br_count, 32'd2);
        check("wrap_miss_count", miss_count, 32'd1);

        // Counters hold at saturation.
        force dut.miss_count_q = 32'hFFFF_FFFF;
        force dut.br_count_q   = 32'hFFFF_FFFF;
        #1;
        release dut.miss_count_q;
        release dut.br_count_q;
        do_push(32'h800, ST_N);
        do_resolve(F3_BEQ, 32'd3, 32'd3, 32'h10, 1'b1, 1'b1, 32'h810);
        check("sat_miss_count", miss_count, 32'hFFFF_FFFF);
        check("sat_br_count", br_count, 32'hFFFF_FFFF);

        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
